// File: rtl/sseg_pkg.sv
// Shared types and constants for the 7-segment scan multiplexer.
package sseg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIT  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Common-anode display: a high anode is dark, a high dp is unlit.
  localparam logic ANODES_OFF = 1'b1;
  localparam logic DP_OFF     = 1'b1;

  typedef logic [3:0] nibble;

endpackage

// File: rtl/sseg_slot_timer.sv
// Slot duration counter: counts 0..last and flags the terminal count.
// The owner clears it on every state change; it never wraps on its own.
module sseg_slot_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] last,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!done) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == last);

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexed scan driver for an N-digit common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int N_DIGITS         = 4,
  parameter int CYCLES_PER_DIGIT = 50000,
  parameter int GAP_CYCLES       = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        load,
  input  logic [4*N_DIGITS-1:0]       data_in,
  input  logic [N_DIGITS-1:0]         dp_in,
  output nibble                       hex,
  output logic                        dp,
  output logic [N_DIGITS-1:0]         an,
  output logic [$clog2(N_DIGITS)-1:0] digit_idx,
  output logic                        frame_tick
);

  localparam int IW   = $clog2(N_DIGITS);
  localparam int MAXC = (CYCLES_PER_DIGIT > GAP_CYCLES) ? CYCLES_PER_DIGIT : GAP_CYCLES;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  state_t                state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic                  boundary;
  logic                  timer_clear, timer_done;
  logic [CW-1:0]         timer_last;
  logic [4*N_DIGITS-1:0] act_data, act_data_nx, sh_data;
  logic [N_DIGITS-1:0]   act_dp, act_dp_nx, sh_dp;
  logic                  pending, apply;
  logic                  blank;
  logic [N_DIGITS-1:0]   an_lit;

  assign timer_last  = (state == GAP) ? CW'(GAP_CYCLES - 1) : CW'(CYCLES_PER_DIGIT - 1);
  assign timer_clear = (state_nx != state) || (state_nx == IDLE);

  sseg_slot_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .last  (timer_last),
    .done  (timer_done)
  );

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    boundary = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: state_nx = LIT;
        LIT:  if (timer_done) state_nx = GAP;
        GAP: begin
          if (timer_done) begin
            state_nx = LIT;
            if (idx == IW'(N_DIGITS - 1)) begin
              idx_nx   = '0;
              boundary = 1'b1;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Shadow reaches the active buffer only at a frame boundary or while dark,
  // so a frame never mixes old and new digits.
  assign apply       = pending && ((state == IDLE) || boundary);
  assign act_data_nx = apply ? sh_data : act_data;
  assign act_dp_nx   = apply ? sh_dp : act_dp;

  always_comb begin
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic higher_zero;
      higher_zero = 1'b1;
      for (int k = N_DIGITS - 1; k >= 1; k--) begin
        higher_zero = higher_zero && (act_data_nx[4*k +: 4] == 4'h0) && !act_dp_nx[k];
        if (k == int'(idx_nx)) blank = higher_zero;
      end
    end
`endif
  end

  always_comb begin
    an_lit         = {N_DIGITS{ANODES_OFF}};
    an_lit[idx_nx] = ~ANODES_OFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      act_data <= '0;
      act_dp   <= '0;
      sh_data  <= '0;
      sh_dp    <= '0;
      pending  <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      act_data <= act_data_nx;
      act_dp   <= act_dp_nx;
      if (load) begin
        sh_data <= data_in;
        sh_dp   <= dp_in;
        pending <= 1'b1;
      end else if (apply) begin
        pending <= 1'b0;
      end
    end
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an         <= {N_DIGITS{ANODES_OFF}};
      hex        <= '0;
      dp         <= DP_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (state_nx == LIT) begin
        hex <= act_data_nx[{idx_nx, 2'b00} +: 4];
        dp  <= ~act_dp_nx[idx_nx];
        an  <= blank ? {N_DIGITS{ANODES_OFF}} : an_lit;
      end else begin
        an <= {N_DIGITS{ANODES_OFF}};
      end
    end
  end

  assign digit_idx = idx;

endmodule
